// File: rtl/bcd_serial_pkg.sv
// Shared types and constants for the serial BCD parity generator.
// Digits arrive LSB first, four bits per digit.
package bcd_serial_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int BITS_PER_DIGIT = 4;
   localparam int BCD_MAX        = 9;
   localparam int BIT_CNT_W      = $clog2(BITS_PER_DIGIT);

   // Parity bit that makes (frame ones + z) odd when odd is set, even otherwise.
   function automatic logic parity_bit(input logic par, input logic x, input logic odd);
      return odd ? ~(par ^ x) : (par ^ x);
   endfunction

endpackage

// File: rtl/bcd_digit_checker.sv
// Per-digit bit counter and BCD range check; flags the 4th bit of each digit
// and whether the digit being completed exceeds the BCD range.
module bcd_digit_checker
   import bcd_serial_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic advance_i,
   input  logic x_i,
   output logic digit_last_o,
   output logic digit_bad_o
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_DIGIT - 1);

   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 h_q, h_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bit_cnt_q <= '0;
         h_q       <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         h_q       <= h_d;
      end
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      h_d       = h_q;
      if (clear_i) begin
         bit_cnt_d = '0;
         h_d       = 1'b0;
      end else if (advance_i) begin
         bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
         if (bit_cnt_q == LAST_BIT) begin
            h_d = 1'b0;
         end else if (bit_cnt_q != '0) begin
            h_d = h_q | x_i;
         end
      end
   end

   assign digit_last_o = (bit_cnt_q == LAST_BIT);

   // Bits 1 and 2 are folded into h, so {b3,h,0,0} exceeds BCD_MAX exactly when b3 & h.
   assign digit_bad_o = digit_last_o & ({x_i, h_q, 2'b00} > 4'(BCD_MAX));

endmodule

// File: rtl/serial_bcd_parity_gen.sv
// Serial BCD frame parity generator: accumulates parity over 4*DIGITS consumed
// bits and presents the parity bit (Mealy) on the frame's last bit.
module serial_bcd_parity_gen
   import bcd_serial_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter bit ERR_STICKY = 1'b1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         x,
   input  logic                         x_valid,
   input  logic                         clear,
   input  logic                         odd_mode,
   output logic                         z,
   output logic                         done,
   output logic                         bcd_err,
   output logic [$clog2(DIGITS+1)-1:0]  digit_idx,
   output logic                         busy
);

   localparam int               IDX_W      = $clog2(DIGITS + 1);
   localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DIGITS - 1);

   state_e           state_q, state_d;
   logic             par_q, par_d;
   logic [IDX_W-1:0] digit_q, digit_d;
   logic             err_q, err_d;

   logic consume;
   logic digit_last;
   logic digit_bad;
   logic frame_last;
   logic err_det;

   // clear wins over a simultaneous x_valid
   assign consume = x_valid & ~clear;

   bcd_digit_checker u_checker (
      .clock        (clock),
      .reset        (reset),
      .clear_i      (clear),
      .advance_i    (consume),
      .x_i          (x),
      .digit_last_o (digit_last),
      .digit_bad_o  (digit_bad)
   );

   assign frame_last = consume & digit_last & (digit_q == LAST_DIGIT);
   assign err_det    = consume & digit_bad;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         par_q   <= 1'b0;
         digit_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         par_q   <= par_d;
         digit_q <= digit_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      par_d   = par_q;
      digit_d = digit_q;
      err_d   = err_q;
      if (clear) begin
         state_d = IDLE;
         par_d   = 1'b0;
         digit_d = '0;
         err_d   = 1'b0;
      end else if (consume) begin
         state_d = RUN;
         par_d   = par_q ^ x;
         if (digit_last) begin
            digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + IDX_W'(1);
         end
         if (err_det) begin
            err_d = 1'b1;
         end
         // Frame end returns to IDLE; the next consumed bit starts a new frame.
         if (frame_last) begin
            state_d = IDLE;
            par_d   = 1'b0;
            err_d   = 1'b0;
         end
      end
   end

   assign done      = frame_last;
   assign z         = frame_last & parity_bit(par_q, x, odd_mode);
   assign bcd_err   = ERR_STICKY ? (err_q | err_det) : err_det;
   assign digit_idx = digit_q;
   assign busy      = (state_q == RUN);

endmodule

// File: doc/serial_bcd_parity_gen.md
SERIAL_BCD_PARITY_GEN -- requirements
Module: serial_bcd_parity_gen

Interface
REQ-001 Parameter DIGITS, default 4, BCD digits per frame; legal range 1..16.
REQ-002 Parameter ERR_STICKY, default 1; 1 = bcd_err holds to end of frame, 0 = bcd_err pulses only on the offending digit's 4th bit.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 x  input  1  serial data bit, LSB of each digit first, digit 0 first.
REQ-006 x_valid  input  1  x is consumed on a rising edge only when x_valid=1.
REQ-007 clear  input  1  synchronous frame abort.
REQ-008 odd_mode  input  1  1 = odd parity, 0 = even parity; sampled per bit, must be held constant within a frame.
REQ-009 z  output  1  parity bit (Mealy), valid only while done=1.
REQ-010 done  output  1  combinational; high during the cycle the frame's last bit is presented with x_valid=1.
REQ-011 bcd_err  output  1  a digit in the current frame exceeded 9.
REQ-012 digit_idx  output  $clog2(DIGITS+1)  index of the digit currently being received.
REQ-013 busy  output  1  at least one bit of the current frame has been consumed.

Function
REQ-014 Frame = 4*DIGITS consumed bits; bit_cnt (0..3) and digit counter advance only on x_valid=1.
REQ-015 States: IDLE (no bits consumed) and RUN; IDLE->RUN on the first consumed bit; RUN->IDLE on consuming the last bit of the frame or on clear.
REQ-016 A running parity register accumulates XOR of consumed bits and resets to 0 when returning to IDLE.
REQ-017 On the last bit: z = ~(par ^ x) when odd_mode=1, and z = par ^ x when odd_mode=0; frame ones-count plus z is then odd or even respectively.
REQ-018 done and z are Mealy, combinational from state and x; there is zero latency from the last bit to done.
REQ-019 Frames are back-to-back; a bit consumed in the cycle after done is bit 0 of the next frame, with no idle gap required.
REQ-020 BCD check per digit: track h = b1|b2; on bit 3, digit is invalid iff b3 & h; raise bcd_err in that same cycle (Mealy).
REQ-021 ERR_STICKY=1: bcd_err is registered-high from the cycle after detection until the frame ends, and is still high during done; it is cleared on IDLE entry.
REQ-022 With x_valid=0, all state, counters and outputs hold, and done=0.
REQ-023 clear=1 forces IDLE, parity=0, counters=0 and error=0 at the next edge; it overrides a simultaneous x_valid, and done is forced to 0 in that cycle.
REQ-024 digit_idx wraps DIGITS-1 -> 0 at frame end; it never reaches DIGITS.
REQ-025 DIGITS=1 degenerates to single-digit operation: done occurs on every 4th consumed bit.

Reset
REQ-026 reset low asynchronously sets state=IDLE, parity=0, bit_cnt=0, digit counter=0 and sticky error=0; outputs z=0, done=0, bcd_err=0, digit_idx=0, busy=0.
REQ-027 A reset asserted mid-frame discards the partial frame; the first bit consumed after deassertion is bit 0 of digit 0.

Structure
REQ-028 Shared package bcd_serial_pkg holds the state enum {IDLE, RUN}, BITS_PER_DIGIT=4 and BCD_MAX=9.
REQ-029 One sub-module, bcd_digit_checker, holds the per-digit bit counter and h flag, and outputs digit_last and digit_bad.

Verification
REQ-030 DIGITS=1, odd_mode=1, bits 1,0,0,1 (digit 9) -> done and z=1 on the 4th bit, bcd_err=0.
REQ-031 DIGITS=2, odd_mode=0, digits 3 then 7 (LSB-first 1,1,0,0,1,1,1,0) -> done on bit 8, z=1 (five ones).
REQ-032 DIGITS=1, bits 0,1,0,1 (digit 10) -> bcd_err=1 on bit 4, simultaneous with done; bcd_err=0 in the next frame.
REQ-033 DIGITS=2, x_valid gaps of 3 cycles between bits -> results identical to the gapless run, and done=0 during the gaps.
REQ-034 clear together with x_valid on bit 5 of 8 -> no done; the next 8 bits form a fresh frame with correct z.
REQ-035 reset pulsed after bit 3 of digit 1 -> all outputs 0; the following 4*DIGITS bits produce a correct done and z.
